ksa_pipe_adder: RTL

//  Pipelined Kogge-Stone adder: computes {cout,sum} = a + b + cin.

---
 rtl/ksa_pipe_adder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder: three-stage pipelined Kogge-Stone adder, {cout,sum} = a + b + cin,
// with valid/ready handshakes on both sides and a single global advance/stall.
module ksa_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int L = $clog2(WIDTH);

  // Prefix vectors are WIDTH+1 wide: position 0 carries cin (bit -1), position j is bit j-1.
  function automatic logic [WIDTH:0] prefix_g(input logic [WIDTH:0] g_in,
                                              input logic [WIDTH:0] p_in,
                                              input int lo, input int hi);
    logic [WIDTH:0] g, p, g_n, p_n;
    g = g_in;
    p = p_in;
    for (int k = 1; k <= L + 1; k++) begin
      if (k >= lo && k <= hi) begin
        g_n = g;
        p_n = p;
        for (int j = 0; j <= WIDTH; j++) begin
          if (j >= (1 << (k - 1))) begin
            g_n[j] = g[j] | (p[j] & g[j - (1 << (k - 1))]);
            p_n[j] = p[j] & p[j - (1 << (k - 1))];
          end
        end
        g = g_n;
        p = p_n;
      end
    end
    return g;
  endfunction

  function automatic logic [WIDTH:0] prefix_p(input logic [WIDTH:0] p_in,
                                              input int lo, input int hi);
    logic [WIDTH:0] p, p_n;
    p = p_in;
    for (int k = 1; k <= L; k++) begin
      if (k >= lo && k <= hi) begin
        p_n = p;
        for (int j = 0; j <= WIDTH; j++) begin
          if (j >= (1 << (k - 1))) begin
            p_n[j] = p[j] & p[j - (1 << (k - 1))];
          end
        end
        p = p_n;
      end
    end
    return p;
  endfunction

  logic             w_advance;
  logic [WIDTH:0]   w_g0, w_p0, w_s2_g, w_s2_p, w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  logic             r_s1_valid, r_s1_cin;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH:0]   r_s2_g, r_s2_p;
  logic [WIDTH-1:0] r_s2_x;
  logic             r_s3_valid, r_cout;
  logic [WIDTH-1:0] r_sum;

  // Every stage moves together; a stall freezes bubbles too.
  assign w_advance = !r_s3_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_g0[0] = r_s1_cin;
  assign w_p0[0] = 1'b0;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gp
    assign w_g0[gi+1] = r_s1_a[gi] & r_s1_b[gi];
    assign w_p0[gi+1] = r_s1_a[gi] ^ r_s1_b[gi];
  end

  assign w_s2_g = prefix_g(w_g0, w_p0, 1, SPLIT);
  assign w_s2_p = prefix_p(w_p0, 1, SPLIT);

  // Level L+1 (span WIDTH) only touches the top position, folding cin into cout.
  assign w_c    = prefix_g(r_s2_g, r_s2_p, SPLIT + 1, L + 1);
  assign w_sum  = r_s2_x ^ w_c[WIDTH-1:0];
  assign w_cout = w_c[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_g     <= '0;
      r_s2_p     <= '0;
      r_s2_x     <= '0;
      r_s3_valid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a   <= a;
        r_s1_b   <= b;
        r_s1_cin <= cin;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_g <= w_s2_g;
        r_s2_p <= w_s2_p;
        r_s2_x <= w_p0[WIDTH:1];
      end
      // Bubbles leave sum/cout untouched.
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
      end
    end
  end

  assign out_valid = r_s3_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
